cluster_encoder: RTL and testbench
==================================

Name: cluster_encoder

Overview:
- Consumer end of the cluster truncator interface.
- Each cycle it takes the 1536-bit truncated VPF vector, whose least-significant 1 has been removed once per cycle upstream, and priority-encodes the lowest set bit into an 11-bit strip address.
- It frames the outputs into 8-sample windows aligned to the truncator's latch phase, producing up to 8 ascending cluster addresses per window, a per-window count, and an overflow flag.
- It is pipelined over 2 stages so the 1536-bit search is not on the truncator's critical path.

Parameters:
- WIDTH, 1536, input vector width
- MXSEGS, 24, number of encode segments
- SEGSIZE, 64, bits per segment (WIDTH/MXSEGS)
- MXCLUSTERS, 8, samples (clusters) per window
- ADRB, 11, address width

Ports:
- clock  input  1  single system clock
- global_reset  input  1  asynchronous, active-high reset
- latch_in  input  1  high on the cycle vpfs_in carries the first (untruncated) sample of a window
- vpfs_in  input  WIDTH  truncated VPF vector, one sample per cycle
- cluster_adr  output  ADRB  strip address of lowest set bit (0..1535)
- cluster_vld  output  1  cluster_adr valid
- cluster_idx  output  3  ordinal of this cluster within the window (0..7)
- frame_done  output  1  one-cycle pulse that closes a window
- cluster_cnt  output  4  valid clusters in the closed window (0..8), qualified by frame_done
- overflow  output  1  qualified by frame_done; window had more than 8 clusters

Behaviour:
- Reset (async assert, sync release to clock): all outputs 0, pipeline valids 0, sample counter 0, encoder idle.
- While idle, samples are ignored; only latch_in starts a window.
- Sample counter: loads 0 on latch_in, otherwise increments to 7. Samples 0..7 are in-window.
- After sample 7 without a new latch_in, the encoder goes idle and ignores samples.
- Stage 1 (registered, per segment):
  - active = OR of the segment.
  - pos = 6-bit index of the lowest set bit.
  - multi = the segment has at least 2 set bits.
  - Also registered: in-window flag, sample index, and a last flag (sample 7 or next-cycle latch_in).
- Stage 2 (registered):
  - Select the lowest active segment s.
  - Address = s*64 + pos[s].
  - cluster_vld = in-window AND any segment active.
  - Idle or empty samples give cluster_vld=0 and cluster_adr=0.
- Latency: a sample on cycle N appears on outputs at cycle N+2.
- cluster_idx: starts at 0 per window and increments only on valid outputs, so empty samples never consume an index.
- frame_done: asserted at N+2 for the sample that closes the window, in the same cycle as that sample's cluster_vld if any.
  - cluster_cnt = number of valids in the window, including that cycle.
- Early latch_in (new window before sample 7): the previous window closes on its last received sample. frame_done for the old window coincides with that sample's output. The new window's first output follows with no gap.
- latch_in every 8 cycles: windows are back-to-back with no dead cycle.
- overflow: set at frame_done when the closing sample had at least 2 set bits, i.e. the lowest active segment has multi, or 2 or more segments are active. Clusters beyond the 8th are dropped, not reported.
- Any bit set in vpfs_in after the window's first sample must be a subset of the prior sample; no check is made.
- Reset mid-window: outputs clear immediately. No frame_done for the aborted window. The next window starts on the next latch_in.

Test Plan:
- Bench emulates the truncator (clear LSB each cycle) with latch_in every 8 cycles.
- Single bit 5, latch at cycle 0 -> cycle 2: vld=1, adr=5, idx=0; cycle 9: frame_done=1, cnt=1, overflow=0.
- Bits {3,64,1535} -> adr 3, 64, 1535 on cycles 2, 3, 4 with idx 0, 1, 2; frame_done cycle 9, cnt=3, overflow=0.
- Bits {0..9} (10 clusters) -> adr 0..7 on cycles 2..9; cycle 9: frame_done=1, cnt=8, overflow=1.
- All-zero window -> no vld; frame_done at cycle 9 with cnt=0, overflow=0.
- Bits {10,20,30,40,50,60}, second latch_in at cycle 4 with bit 100 -> frame_done cycle 5 with cnt=4 (adr 10, 20, 30, 40); cycle 6: adr=100, idx=0.
- global_reset asserted at cycle 3 of a 5-cluster window -> outputs 0 the same cycle, no frame_done; the next latch_in window encodes normally.

Source files
------------

// File: rtl/cluster_encoder_if.sv
// Truncator-to-encoder bus: the truncated VPF sample stream and the framed
// cluster addresses that come back from the encoder.
interface cluster_encoder_if #(
  parameter int WIDTH = 1536,
  parameter int ADRB  = 11
);
  logic             latch_in;
  logic [WIDTH-1:0] vpfs_in;
  logic [ADRB-1:0]  cluster_adr;
  logic             cluster_vld;
  logic [2:0]       cluster_idx;
  logic             frame_done;
  logic [3:0]       cluster_cnt;
  logic             overflow;

  modport master (
    output latch_in, vpfs_in,
    input  cluster_adr, cluster_vld, cluster_idx, frame_done, cluster_cnt, overflow
  );

  modport slave (
    input  latch_in, vpfs_in,
    output cluster_adr, cluster_vld, cluster_idx, frame_done, cluster_cnt, overflow
  );
endinterface

// File: rtl/cluster_encoder.sv
// Two-stage priority encoder for the truncated VPF vector: segment-local encode,
// then lowest-segment select, framed into 8-sample windows set by latch_in.
module cluster_encoder #(
  parameter int WIDTH      = 1536,
  parameter int MXSEGS     = 24,
  parameter int SEGSIZE    = 64,
  parameter int MXCLUSTERS = 8,
  parameter int ADRB       = 11
) (
  input logic              clock,
  input logic              global_reset,
  cluster_encoder_if.slave bus
);
  localparam int         POSB        = $clog2(SEGSIZE);
  localparam int         SEGB        = $clog2(MXSEGS);
  localparam logic [2:0] LAST_SAMPLE = 3'(MXCLUSTERS - 1);

  typedef enum logic {IDLE, FRAMING} state_t;

  state_t     state, state_nxt;
  logic [2:0] samp_cnt, samp_nxt;
  logic       in_win0;

  // samp_cnt holds the index of the sample accepted on the previous cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    samp_nxt  = samp_cnt;
    in_win0   = 1'b0;
    if (bus.latch_in) begin
      state_nxt = FRAMING;
      samp_nxt  = '0;
      in_win0   = 1'b1;
    end else if (state == FRAMING) begin
      if (samp_cnt == LAST_SAMPLE) begin
        state_nxt = IDLE;
      end else begin
        samp_nxt = samp_cnt + 3'd1;
        in_win0  = 1'b1;
      end
    end
  end

  // Segment-local encode of the raw input vector.
  logic [MXSEGS-1:0] seg_act_c, seg_multi_c;
  logic [POSB-1:0]   seg_pos_c [MXSEGS];
  logic [SEGSIZE-1:0] seg;

  always_comb begin
    seg = '0;
    for (int s = 0; s < MXSEGS; s++) begin
      seg            = bus.vpfs_in[s*SEGSIZE +: SEGSIZE];
      seg_act_c[s]   = |seg;
      seg_multi_c[s] = |(seg & (seg - SEGSIZE'(1)));
      seg_pos_c[s]   = '0;
      for (int b = SEGSIZE - 1; b >= 0; b--) begin
        if (seg[b]) seg_pos_c[s] = POSB'(b);
      end
    end
  end

  logic              s1_in_win, s1_last;
  logic [2:0]        s1_idx;
  logic [MXSEGS-1:0] s1_act, s1_multi;
  logic [POSB-1:0]   s1_pos [MXSEGS];

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= IDLE;
      samp_cnt  <= '0;
      s1_in_win <= 1'b0;
    end else begin
      state     <= state_nxt;
      samp_cnt  <= samp_nxt;
      s1_in_win <= in_win0;
    end
  end

  // NOTE: the stage-1 datapath has no reset; everything it feeds is qualified by s1_in_win.
  always_ff @(posedge clock) begin
    s1_idx   <= samp_nxt;
    s1_last  <= (samp_nxt == LAST_SAMPLE);
    s1_act   <= seg_act_c;
    s1_multi <= seg_multi_c;
    s1_pos   <= seg_pos_c;
  end

  // Stage 2: lowest active segment, window close and per-window bookkeeping.
  logic [SEGB-1:0] sel;
  logic            any_act, two_seg, vld_c, close_c;
  logic [ADRB-1:0] adr_c;
  logic [3:0]      base_c, cnt_c, vcnt;

  always_comb begin
    sel = '0;
    for (int s = MXSEGS - 1; s >= 0; s--) begin
      if (s1_act[s]) sel = SEGB'(s);
    end
    any_act = |s1_act;
    two_seg = |(s1_act & (s1_act - MXSEGS'(1)));
    adr_c   = ADRB'(sel) * ADRB'(SEGSIZE) + ADRB'(s1_pos[sel]);
    vld_c   = s1_in_win & any_act;
    // A window also closes early when the next sample is a fresh latch.
    close_c = s1_in_win & (s1_last | bus.latch_in);
    base_c  = (s1_idx == 3'd0) ? 4'd0 : vcnt;
    cnt_c   = base_c + {3'd0, vld_c};
  end

  logic [ADRB-1:0] adr_q;
  logic            vld_q, done_q, ovf_q;
  logic [2:0]      idx_q;
  logic [3:0]      cnt_q;

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      adr_q  <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      vcnt   <= '0;
    end else begin
      adr_q  <= vld_c ? adr_c : '0;
      vld_q  <= vld_c;
      idx_q  <= vld_c ? base_c[2:0] : '0;
      done_q <= close_c;
      cnt_q  <= close_c ? cnt_c : '0;
      ovf_q  <= close_c & (two_seg | s1_multi[sel]);
      if (s1_in_win) vcnt <= cnt_c;
    end
  end

  assign bus.cluster_adr = adr_q;
  assign bus.cluster_vld = vld_q;
  assign bus.cluster_idx = idx_q;
  assign bus.frame_done  = done_q;
  assign bus.cluster_cnt = cnt_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_cluster_encoder.sv
// Self-checking bench for cluster_encoder: emulates the truncator, checks every
// cycle against a window-level reference model plus a table of directed vectors.
`timescale 1ns/1ps
module tb_cluster_encoder;
  localparam int WIDTH = 1536;

  logic clock = 1'b0;
  logic global_reset = 1'b1;
  always #5 clock = ~clock;

  cluster_encoder_if #(.WIDTH(WIDTH), .ADRB(11)) bus ();
  cluster_encoder dut (.clock(clock), .global_reset(global_reset), .bus(bus));

  typedef struct packed {
    logic        vld;
    logic [10:0] adr;
    logic [2:0]  idx;
    logic        fd;
    logic [3:0]  cnt;
    logic        ovf;
  } out_t;

  typedef struct packed {
    logic             lat;
    logic [WIDTH-1:0] vec;
  } smp_t;

  typedef struct {
    int   scen;
    int   cyc;
    out_t exp;
  } dvec_t;

  int    passed = 0;
  int    total  = 0;
  int    m_pos  = -1;
  int    m_cnt  = 0;
  int    rel    = -1;
  smp_t  hq[$];
  out_t  obs[32];
  dvec_t dtab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: window position, lowest set bit and popcount straight from the rules.
  function automatic out_t model(input smp_t s, input logic next_lat);
    out_t o;
    int   n, low;
    logic in_win;
    o = '0;
    if (s.lat) m_pos = 0;
    else if (m_pos >= 0 && m_pos < 7) m_pos++;
    else m_pos = -1;
    in_win = (m_pos >= 0);
    n = $countones(s.vec);
    low = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (s.vec[i]) low = i;
    if (m_pos == 0) m_cnt = 0;
    if (in_win && n > 0) begin
      o.vld = 1'b1;
      o.adr = 11'(low);
      o.idx = 3'(m_cnt);
      m_cnt++;
    end
    if (in_win && (m_pos == 7 || next_lat)) begin
      o.fd  = 1'b1;
      o.cnt = 4'(m_cnt);
      o.ovf = (n >= 2);
    end
    return o;
  endfunction

  task automatic cycle(input logic lat, input logic [WIDTH-1:0] vec, input logic rst_v);
    out_t e, a;
    smp_t s;
    @(posedge clock); #1;
    bus.latch_in = lat;
    bus.vpfs_in  = vec;
    global_reset = rst_v;
    e = '0;
    if (rst_v) begin
      hq.delete();
      m_pos = -1;
      m_cnt = 0;
    end else begin
      s.lat = lat;
      s.vec = vec;
      hq.push_back(s);
      if (hq.size() == 3) begin
        e = model(hq[0], hq[1].lat);
        void'(hq.pop_front());
      end
    end
    @(negedge clock);
    a.vld = bus.cluster_vld;
    a.adr = bus.cluster_adr;
    a.idx = bus.cluster_idx;
    a.fd  = bus.frame_done;
    a.cnt = bus.cluster_cnt;
    a.ovf = bus.overflow;
    if (rel >= 0 && rel < 32) obs[rel] = a;
    check("model cluster_vld", 32'(a.vld), 32'(e.vld));
    check("model cluster_adr", 32'(a.adr), 32'(e.adr));
    check("model cluster_idx", 32'(a.idx), 32'(e.idx));
    check("model frame_done",  32'(a.fd),  32'(e.fd));
    check("model cluster_cnt", 32'(a.cnt), 32'(e.cnt));
    check("model overflow",    32'(a.ovf), 32'(e.ovf));
  endtask

  function automatic void add(input int scen, input int cyc, input logic vld, input int adr,
                              input int idx, input logic fd, input int cnt, input logic ovf);
    dvec_t d;
    d.scen = scen;
    d.cyc  = cyc;
    d.exp  = {vld, 11'(adr), 3'(idx), fd, 4'(cnt), ovf};
    dtab.push_back(d);
  endfunction

  // Truncator emulation: latch at cycle 0 (and optionally l2), clear the LSB otherwise.
  task automatic run_scen(input int scen, input logic [WIDTH-1:0] va, input int l2,
                          input logic [WIDTH-1:0] vb, input int rst_on, input int rst_off);
    logic [WIDTH-1:0] cur;
    logic             lat, r;
    out_t             a, x;
    cur = '0;
    r   = 1'b0;
    for (int c = 0; c < 16; c++) begin
      lat = 1'b0;
      if (c == 0) begin
        lat = 1'b1;
        cur = va;
      end else if (c == l2) begin
        lat = 1'b1;
        cur = vb;
      end else begin
        cur = cur & (cur - 1'b1);
      end
      if (c == rst_on)  r = 1'b1;
      if (c == rst_off) r = 1'b0;
      rel = c;
      cycle(lat, cur, r);
    end
    rel = -1;
    foreach (dtab[i]) begin
      if (dtab[i].scen == scen) begin
        a = obs[dtab[i].cyc];
        x = dtab[i].exp;
        check($sformatf("S%0d c%0d vld", scen, dtab[i].cyc), 32'(a.vld), 32'(x.vld));
        check($sformatf("S%0d c%0d adr", scen, dtab[i].cyc), 32'(a.adr), 32'(x.adr));
        check($sformatf("S%0d c%0d idx", scen, dtab[i].cyc), 32'(a.idx), 32'(x.idx));
        check($sformatf("S%0d c%0d fd",  scen, dtab[i].cyc), 32'(a.fd),  32'(x.fd));
        check($sformatf("S%0d c%0d cnt", scen, dtab[i].cyc), 32'(a.cnt), 32'(x.cnt));
        check($sformatf("S%0d c%0d ovf", scen, dtab[i].cyc), 32'(a.ovf), 32'(x.ovf));
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] va, vb, cur, noise;
    int               per, k, base, mode, sel;

    bus.latch_in = 1'b0;
    bus.vpfs_in  = '0;

    // Directed expectations: scen, cycle, vld, adr, idx, frame_done, cnt, overflow.
    add(0, 2, 1, 5, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0, 0, 0);
    add(0, 9, 0, 0, 0, 1, 1, 0);
    add(1, 2, 1, 3, 0, 0, 0, 0);
    add(1, 3, 1, 64, 1, 0, 0, 0);
    add(1, 4, 1, 1535, 2, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0, 0);
    add(1, 9, 0, 0, 0, 1, 3, 0);
    for (int i = 0; i < 7; i++) add(2, 2 + i, 1, i, i, 0, 0, 0);
    add(2, 9, 1, 7, 7, 1, 8, 1);
    add(2, 10, 0, 0, 0, 0, 0, 0);
    add(3, 2, 0, 0, 0, 0, 0, 0);
    add(3, 9, 0, 0, 0, 1, 0, 0);
    add(4, 2, 1, 10, 0, 0, 0, 0);
    add(4, 3, 1, 20, 1, 0, 0, 0);
    add(4, 4, 1, 30, 2, 0, 0, 0);
    add(4, 5, 1, 40, 3, 1, 4, 1);
    add(4, 6, 1, 100, 0, 0, 0, 0);
    add(4, 7, 0, 0, 0, 0, 0, 0);
    add(4, 13, 0, 0, 0, 1, 1, 0);
    add(5, 2, 1, 1, 0, 0, 0, 0);
    add(5, 3, 0, 0, 0, 0, 0, 0);
    add(5, 4, 0, 0, 0, 0, 0, 0);
    add(5, 8, 1, 7, 0, 0, 0, 0);
    add(5, 9, 0, 0, 0, 0, 0, 0);
    add(5, 15, 0, 0, 0, 1, 1, 0);

    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

    va = '0; va[5] = 1'b1;
    run_scen(0, va, -1, '0, -1, -1);
    va = '0; va[3] = 1'b1; va[64] = 1'b1; va[1535] = 1'b1;
    run_scen(1, va, -1, '0, -1, -1);
    va = '0; for (int i = 0; i < 10; i++) va[i] = 1'b1;
    run_scen(2, va, -1, '0, -1, -1);
    run_scen(3, '0, -1, '0, -1, -1);
    va = '0; for (int i = 1; i <= 6; i++) va[10*i] = 1'b1;
    vb = '0; vb[100] = 1'b1;
    run_scen(4, va, 4, vb, -1, -1);
    va = '0; for (int i = 1; i <= 5; i++) va[i] = 1'b1;
    vb = '0; vb[7] = 1'b1;
    run_scen(5, va, 6, vb, 3, 5);

    // Random windows: mostly back-to-back, some early latches, some idle gaps with noise.
    for (int w = 0; w < 60; w++) begin
      sel = $urandom_range(0, 9);
      per = (sel < 6) ? 8 : (sel < 8) ? $urandom_range(2, 7) : $urandom_range(9, 12);
      k    = $urandom_range(0, 12);
      base = $urandom_range(0, WIDTH - 64);
      mode = $urandom_range(0, 1);
      cur  = '0;
      for (int j = 0; j < k; j++) begin
        if (mode == 1) cur[base + $urandom_range(0, 63)] = 1'b1;
        else           cur[$urandom_range(0, WIDTH - 1)] = 1'b1;
      end
      for (int c = 0; c < per; c++) begin
        if (c == 0) begin
          cycle(1'b1, cur, 1'b0);
        end else if (c < 8) begin
          cur = cur & (cur - 1'b1);
          cycle(1'b0, cur, 1'b0);
        end else begin
          for (int q = 0; q < WIDTH / 32; q++) noise[q*32 +: 32] = $urandom;
          cycle(1'b0, noise, 1'b0);
        end
      end
    end

    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
